// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides; registered result and zero flag.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 1010).
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic             r_rdy_en;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_load_val;
  logic [SHW-1:0]   w_sh;
  logic             w_accept;
  logic             w_consume;
  logic             w_load;
  logic             w_idle;

  assign w_sh      = inp2[SHW-1:0];
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  // Single-cycle datapath works straight off the live inputs; it is only
  // sampled on the accept edge.
  always_comb begin
    w_alu = inp1;
    case (alu_control)
      OP_AND:  w_alu = inp1 & inp2;
      OP_SLL:  w_alu = inp1 << w_sh;
      OP_ADD:  w_alu = inp1 + inp2;
      OP_OR:   w_alu = inp1 | inp2;
      OP_SUB:  w_alu = inp1 - inp2;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
      OP_XOR:  w_alu = inp1 ^ inp2;
      OP_SRL:  w_alu = inp1 >> w_sh;
      OP_SRA:  w_alu = $signed(inp1) >>> w_sh;
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (inp1 < inp2)};
      default: w_alu = inp1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_nxt;
  logic [SHW-1:0]   r_cnt;
  logic             w_is_mul;
  logic             w_mul_done;

  assign w_is_mul   = (alu_control == OP_MUL);
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done)           w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // LSB-first shift-add: multiplicand walks left, multiplier walks right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= inp1;
      r_mplier <= inp2;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_nxt;
      r_cnt    <= r_cnt + SHW'(1);
    end
  end

  assign w_idle     = (r_state == S_IDLE);
  assign w_load     = (w_accept && !w_is_mul) || w_mul_done;
  assign w_load_val = w_mul_done ? w_acc_nxt : w_alu;
`else
  assign w_idle     = 1'b1;
  assign w_load     = w_accept;
  assign w_load_val = w_alu;
`endif

  // r_rdy_en keeps in_ready low until the first edge after reset release.
  assign in_ready = r_rdy_en && w_idle && (!r_out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_load_val;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign alu_zero   = (r_result == '0);

endmodule
